// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round-core sequencer: FSM states,
// word addresses of the register map and CTRL/STATUS bit positions.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_KEY0   = 4'd2;
  localparam logic [3:0] ADDR_DIN0   = 4'd6;
  localparam logic [3:0] ADDR_DOUT0  = 4'd10;
  localparam logic [3:0] ADDR_RSVD   = 4'd14;

  localparam int CTRL_START_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_TIMEOUT_BIT = 2;

endpackage

// File: rtl/aes_ctrl_if.sv
// Peripheral strobe bus between the CPU address decode (master) and the
// AES sequencer (slave).
interface aes_ctrl_if;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport slave  (input stb_i, we_i, addr_i, wdata_i, output rdata_o, ack_o);
  modport master (output stb_i, we_i, addr_i, wdata_i, input rdata_o, ack_o);
endinterface

// File: rtl/aes_ctrl_regfile.sv
// KEY/DIN/DOUT word storage and the registered read-data mux of the AES
// sequencer. CTRL and STATUS words are supplied by the parent.
module aes_ctrl_regfile
  import aes_ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         i_rd_en,
  input  logic         i_wr_en,
  input  logic [3:0]   i_addr,
  input  logic [31:0]  i_wdata,
  input  logic         i_dout_load,
  input  logic [127:0] i_dout,
  input  logic [31:0]  i_ctrl_word,
  input  logic [31:0]  i_status_word,
  output logic [127:0] o_key,
  output logic [127:0] o_din,
  output logic [31:0]  o_rdata
);

  logic [3:0][31:0] r_key, r_din, r_dout;
  logic [31:0]      r_rdata;
  logic [31:0]      w_rd_word;
  logic [1:0]       w_key_idx, w_din_idx, w_dout_idx;
  logic             w_in_key, w_in_din, w_in_dout;

  assign w_key_idx  = 2'(i_addr - ADDR_KEY0);
  assign w_din_idx  = 2'(i_addr - ADDR_DIN0);
  assign w_dout_idx = 2'(i_addr - ADDR_DOUT0);
  assign w_in_key   = (i_addr >= ADDR_KEY0)  && (i_addr < ADDR_DIN0);
  assign w_in_din   = (i_addr >= ADDR_DIN0)  && (i_addr < ADDR_DOUT0);
  assign w_in_dout  = (i_addr >= ADDR_DOUT0) && (i_addr < ADDR_RSVD);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rd_word = '0;
    if (i_addr == ADDR_CTRL)        w_rd_word = i_ctrl_word;
    else if (i_addr == ADDR_STATUS) w_rd_word = i_status_word;
    else if (w_in_key)              w_rd_word = r_key[w_key_idx];
    else if (w_in_din)              w_rd_word = r_din[w_din_idx];
    else if (w_in_dout)             w_rd_word = r_dout[w_dout_idx];
  end

  // NOTE: the word arrays are plain flops with reset, so no stale key survives a reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_key   <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_rdata <= '0;
    end else begin
      r_rdata <= i_rd_en ? w_rd_word : '0;
      if (i_wr_en && w_in_key) r_key[w_key_idx] <= i_wdata;
      if (i_wr_en && w_in_din) r_din[w_din_idx] <= i_wdata;
      if (i_dout_load)         r_dout           <= i_dout;
    end
  end

  assign o_key   = r_key;
  assign o_din   = r_din;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/aes_ctrl.sv
// Memory-mapped sequencer for one AES round core: launch, wait with timeout,
// capture ciphertext, level irq. Optional scope trigger: AES_CTRL_TRIGGER_EN.
module aes_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit IRQ_DEFAULT_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  aes_ctrl_if.slave    bus,
  output logic [127:0] core_key_o,
  output logic [127:0] core_din_o,
  output logic         core_start_o,
  input  logic         core_done_i,
  input  logic [127:0] core_dout_i,
  output logic         irq_o,
  input  logic         irq_ack_i,
  output logic         trigger_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_ack, r_irq_en, r_done, r_timeout, r_irq;
  logic        w_acc, w_wr, w_rd, w_busy, w_ctrl_wr, w_status_wr;
  logic        w_start_go, w_done_w1c, w_timeout_w1c;
  logic        w_launch, w_core_done, w_timeout_hit;
  logic [31:0] w_ctrl_word, w_status_word, w_rdata;

  // A held strobe is accepted only on cycles where no ack is pending.
  assign w_acc         = bus.stb_i & ~r_ack;
  assign w_wr          = w_acc & bus.we_i;
  assign w_rd          = w_acc & ~bus.we_i;
  assign w_busy        = (r_state != IDLE);
  assign w_ctrl_wr     = w_wr && (bus.addr_i == ADDR_CTRL);
  assign w_status_wr   = w_wr && (bus.addr_i == ADDR_STATUS);
  assign w_start_go    = w_ctrl_wr & bus.wdata_i[CTRL_START_BIT] & ~w_busy;
  assign w_done_w1c    = w_status_wr & bus.wdata_i[STATUS_DONE_BIT];
  assign w_timeout_w1c = w_status_wr & bus.wdata_i[STATUS_TIMEOUT_BIT];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_launch      = 1'b0;
    w_core_done   = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: if (w_start_go) w_state_nxt = LAUNCH;
      LAUNCH: begin
        w_launch    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Completion on the final counted cycle still wins over the timeout.
        if (core_done_i) begin
          w_core_done = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ack     <= 1'b0;
      r_irq_en  <= IRQ_DEFAULT_EN;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ack <= bus.stb_i & ~r_ack;
      if (w_ctrl_wr) r_irq_en <= bus.wdata_i[CTRL_IRQ_EN_BIT];

      if (w_start_go)       r_done <= 1'b0;
      else if (w_core_done) r_done <= 1'b1;
      else if (w_done_w1c)  r_done <= 1'b0;

      if (w_start_go)          r_timeout <= 1'b0;
      else if (w_timeout_hit)  r_timeout <= 1'b1;
      else if (w_timeout_w1c)  r_timeout <= 1'b0;

      if (w_core_done && r_irq_en)      r_irq <= 1'b1;
      else if (irq_ack_i || w_done_w1c) r_irq <= 1'b0;
    end
  end

  always_comb begin
    w_ctrl_word                       = '0;
    w_ctrl_word[CTRL_IRQ_EN_BIT]      = r_irq_en;
    w_status_word                     = '0;
    w_status_word[STATUS_BUSY_BIT]    = w_busy;
    w_status_word[STATUS_DONE_BIT]    = r_done;
    w_status_word[STATUS_TIMEOUT_BIT] = r_timeout;
  end

  aes_ctrl_regfile u_regfile (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .i_rd_en       (w_rd),
    .i_wr_en       (w_wr & ~w_busy),
    .i_addr        (bus.addr_i),
    .i_wdata       (bus.wdata_i),
    .i_dout_load   (w_core_done),
    .i_dout        (core_dout_i),
    .i_ctrl_word   (w_ctrl_word),
    .i_status_word (w_status_word),
    .o_key         (core_key_o),
    .o_din         (core_din_o),
    .o_rdata       (w_rdata)
  );

  assign bus.rdata_o  = w_rdata;
  assign bus.ack_o    = r_ack;
  assign core_start_o = w_launch;
  assign irq_o        = r_irq;

`ifdef AES_CTRL_TRIGGER_EN
  assign trigger_o = w_busy;
`else
  assign trigger_o = 1'b0;
`endif

endmodule
